// File: rtl/swerv_types.sv
// ---------------------------------------------------------------------------
// swerv_types : shared encodings for the DCCM port arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package swerv_types;

  typedef enum logic [0:0] {
    NORM  = 1'b0,
    FORCE = 1'b1
  } arb_state_e;

  typedef enum logic [0:0] {
    OWNER_LSU = 1'b0,
    OWNER_DMA = 1'b1
  } rsp_owner_e;

  localparam int unsigned STARVE_CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/dccm_port_arb.sv
// ---------------------------------------------------------------------------
// dccm_port_arb : LSU/DMA arbiter in front of the DCCM macro ports
// Rev 1.0
// ---------------------------------------------------------------------------
`ifndef RV_DCCM_BITS
`define RV_DCCM_BITS 16
`endif
`ifndef RV_DCCM_FDATA_WIDTH
`define RV_DCCM_FDATA_WIDTH 39
`endif

`default_nettype none

module dccm_port_arb
  import swerv_types::*;
#(
  parameter int AW         = `RV_DCCM_BITS,
  parameter int DW         = `RV_DCCM_FDATA_WIDTH,
  parameter int STARVE_MAX = 15
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic          lsu_freeze_dc3,
  input  logic          lsu_req,
  input  logic          lsu_wr,
  input  logic [AW-1:0] lsu_addr,
  input  logic [DW-1:0] lsu_wdata,
  output logic          lsu_gnt,
  input  logic          dma_req,
  input  logic          dma_wr,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dccm_wren,
  output logic          dccm_rden,
  output logic [AW-1:0] dccm_wr_addr,
  output logic [AW-1:0] dccm_rd_addr_lo,
  output logic [DW-1:0] dccm_wr_data,
  input  logic [DW-1:0] dccm_rd_data_lo,
  output logic          lsu_rvalid,
  output logic          dma_rvalid,
  output logic [DW-1:0] rd_data
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

  arb_state_e              state_q, state_d;
  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                    rsp_vld_q, rsp_vld_d;
  rsp_owner_e              rsp_own_q, rsp_own_d;

  logic                    dma_pri;
  logic                    lsu_win;
  logic                    dma_win;
  logic                    wr_go;
  logic                    rd_go;
  logic [AW-1:0]           sel_addr;
  logic [DW-1:0]           sel_wdata;

  // DMA takes priority once forced, or in the very cycle the counter saturates.
  always_comb begin
    lsu_win = 1'b0;
    dma_win = 1'b0;
    dma_pri = (state_q == FORCE) || (starve_cnt_q == STARVE_LIM);
    if (!lsu_freeze_dc3) begin
      if (dma_pri) begin
        dma_win = dma_req;
        lsu_win = lsu_req & ~dma_req;
      end else begin
        lsu_win = lsu_req;
        dma_win = dma_req & ~lsu_req;
      end
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    state_d      = state_q;
    if (!dma_req || dma_win) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != STARVE_LIM) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
    case (state_q)
      NORM: begin
        if (dma_req && !dma_win && (starve_cnt_d == STARVE_LIM)) begin
          state_d = FORCE;
        end
      end
      FORCE: begin
        if (dma_win || !dma_req) begin
          state_d = NORM;
        end
      end
      default: state_d = NORM;
    endcase
  end

  always_comb begin
    wr_go     = (lsu_win & lsu_wr) | (dma_win & dma_wr);
    rd_go     = (lsu_win & ~lsu_wr) | (dma_win & ~dma_wr);
    sel_addr  = dma_win ? dma_addr : lsu_addr;
    sel_wdata = dma_win ? dma_wdata : lsu_wdata;
    rsp_vld_d = rd_go;
    rsp_own_d = dma_win ? OWNER_DMA : OWNER_LSU;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q      <= NORM;
      starve_cnt_q <= '0;
      rsp_vld_q    <= 1'b0;
      rsp_own_q    <= OWNER_LSU;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp_own_q    <= rsp_own_d;
    end
  end

  // Combinational outputs are held low while reset is asserted.
  assign lsu_gnt         = lsu_win & rst_l;
  assign dma_gnt         = dma_win & rst_l;
  assign dccm_wren       = wr_go & rst_l;
  assign dccm_rden       = rd_go & rst_l;
  assign dccm_wr_addr    = sel_addr & {AW{rst_l}};
  assign dccm_rd_addr_lo = sel_addr & {AW{rst_l}};
  assign dccm_wr_data    = sel_wdata & {DW{rst_l}};

  assign lsu_rvalid = rsp_vld_q & (rsp_own_q == OWNER_LSU);
  assign dma_rvalid = rsp_vld_q & (rsp_own_q == OWNER_DMA);
  assign rd_data    = dccm_rd_data_lo;

endmodule

`default_nettype wire

// File: doc/dccm_port_arb.md
DCCM_PORT_ARB -- requirements
Module: dccm_port_arb

Interface
REQ-001 Parameter AW, default `RV_DCCM_BITS: DCCM byte-address width.
REQ-002 Parameter DW, default `RV_DCCM_FDATA_WIDTH: DCCM data width, including ECC.
REQ-003 Parameter STARVE_MAX, default 15: number of consecutive DMA denials that forces a DMA grant; legal range 1..15.
REQ-004 Ports, one per line: name, direction, width, meaning.
- clk  in  1  core clock, the only clock.
- rst_l  in  1  reset, asynchronous, active-low.
- lsu_freeze_dc3  in  1  freeze; blocks new grants.
- lsu_req  in  1  LSU access request.
- lsu_wr  in  1  LSU request is a write.
- lsu_addr  in  AW  LSU address.
- lsu_wdata  in  DW  LSU write data.
- lsu_gnt  out  1  LSU access accepted this cycle.
- dma_req  in  1  DMA access request.
- dma_wr  in  1  DMA request is a write.
- dma_addr  in  AW  DMA address.
- dma_wdata  in  DW  DMA write data.
- dma_gnt  out  1  DMA access accepted this cycle.
- dccm_wren  out  1  write enable to the DCCM macro.
- dccm_rden  out  1  read enable to the DCCM macro.
- dccm_wr_addr  out  AW  write address to the DCCM macro.
- dccm_rd_addr_lo  out  AW  read address to the DCCM macro.
- dccm_wr_data  out  DW  write data to the DCCM macro.
- dccm_rd_data_lo  in  DW  read data from the DCCM macro, one cycle after dccm_rden.
- lsu_rvalid  out  1  read data valid for the LSU.
- dma_rvalid  out  1  read data valid for the DMA.
- rd_data  out  DW  read data, shared by both requesters.

Function
REQ-005 Grants are combinational from the current-cycle requests, the FSM state and the starvation count.
REQ-006 The block grants at most one requester per cycle.
REQ-007 The block grants nothing while lsu_freeze_dc3=1.
REQ-008 FSM states:
- NORM: LSU has priority.
- FORCE: DMA has priority.
REQ-009 FSM transitions:
- NORM -> FORCE when starve_cnt reaches STARVE_MAX.
- FORCE -> NORM on any cycle with dma_gnt=1.
- FORCE -> NORM when dma_req drops.
REQ-010 starve_cnt is a 4-bit counter that increments in any cycle with dma_req=1 and dma_gnt=0.
REQ-011 starve_cnt saturates at STARVE_MAX, does not wrap, and clears on dma_gnt=1 or dma_req=0.
REQ-012 Frozen cycles increment starve_cnt.
REQ-013 In the granted cycle, the winner's address and data pass to the dccm_* outputs with zero latency.
REQ-014 For a granted write: dccm_wren=1, dccm_rden=0.
REQ-015 For a granted read: dccm_rden=1, dccm_wren=0.
REQ-016 With no grant, dccm_wren=0 and dccm_rden=0.
REQ-017 The address outputs hold the winner's address and the data output holds the winner's write data.
REQ-018 With no grant, the address and data outputs hold the LSU fields.
REQ-019 Read latency is exactly one cycle: a read granted in cycle N drives the matching rvalid in cycle N+1.
REQ-020 rd_data is dccm_rd_data_lo, passed through combinationally.
REQ-021 The response owner and valid bit are registered, so lsu_rvalid and dma_rvalid are never both 1.
REQ-022 Freeze does not suppress a response still pending from the previous cycle.
REQ-023 A back-to-back read every cycle produces an rvalid every cycle.
REQ-024 Simultaneous requests in NORM: LSU wins unless starve_cnt equals STARVE_MAX.
REQ-025 A grant does not depend on the request type, so a read and a write receive the same arbitration.

Reset
REQ-026 On rst_l=0, asynchronously: state=NORM, starve_cnt=0, response valid=0, response owner=LSU.
REQ-027 During reset, all outputs are 0 except rd_data, which follows dccm_rd_data_lo.
REQ-028 A reset that asserts with a read in flight drops the read's rvalid.
REQ-029 After reset deasserts, the first grant can occur in the first clock edge's cycle.

Structure
REQ-030 The state enum (NORM, FORCE) and the owner encoding (LSU=0, DMA=1) belong in swerv_types.
REQ-031 The block is a single module with no sub-module.
REQ-032 The block instantiates in front of the DCCM instance inside mem, on the DCCM ports only.

Verification
REQ-033 Reset check: assert rst_l=0 mid-read -> lsu_rvalid=0 and dma_rvalid=0 immediately; starve_cnt=0.
REQ-034 LSU read: lsu_req=1, lsu_wr=0, addr=0x40 -> lsu_gnt=1, dccm_rden=1, rd_addr_lo=0x40; next cycle lsu_rvalid=1 and rd_data equals the macro data.
REQ-035 Starvation: lsu_req and dma_req both held at 1 for 20 cycles -> dma_gnt=1 exactly in cycle 16; lsu_gnt=1 in all other cycles.
REQ-036 Freeze: lsu_freeze_dc3=1 for 3 cycles, in the cycle after a DMA read grant -> dma_rvalid=1 in the first freeze cycle; no grants for the 3 cycles.
REQ-037 DMA write: dma_req=1, dma_wr=1, addr=0x1F8, data=0x5A5A5A5A5 with LSU idle -> dma_gnt=1, dccm_wren=1, wr_addr=0x1F8; no rvalid follows.
REQ-038 Alternating reads: LSU read, DMA read, LSU read in consecutive cycles -> rvalid owners in the following cycles are LSU, DMA, LSU, and the two rvalid outputs are never both 1.
